avalon_fft_csr_slave: RTL and testbench
=======================================

// Module: avalon_fft_csr_slave
// PURPOSE
//  Parametrised Avalon-MM slave between the host bus and the FFT core. Forwards
//  sample writes into the FFT input memory, provides CTRL/STATUS/COUNT registers
//  and reads back FFT results. Sequences load -> start -> busy -> done.
// PARAMETERS
//  DATA_W     16   bus, sample and result data width
//  N_SAMPLES  512  FFT length; must be a power of 2
//  ADDR_W     10   slave_address width = $clog2(N_SAMPLES)+1; SAMP_AW = ADDR_W-1
// PORTS
//  clk                 in   1        system clock, all logic on rising edge
//  n_rst               in   1        asynchronous active-low reset
//  slave_chipselect    in   1        Avalon chipselect; read/write ignored when 0
//  slave_read          in   1        Avalon read strobe
//  slave_write         in   1        Avalon write strobe
//  slave_address       in   ADDR_W   word address (map below)
//  slave_writedata     in   DATA_W   write data
//  slave_readdata      out  DATA_W   read data, valid with slave_readdatavalid
//  slave_readdatavalid out  1        one-cycle pulse, fixed read latency 2
//  sWriteEn            out  1        FFT input memory write enable
//  wAddress            out  SAMP_AW  FFT input memory write address
//  fft_init_data       out  DATA_W   FFT input memory write data
//  fft_start           out  1        one-cycle start pulse to FFT core
//  fft_done            in   1        one-cycle completion pulse from FFT core
//  rAddress            out  SAMP_AW  FFT result memory read address
//  fft_result_data     in   DATA_W   result memory data, 1 cycle after rAddress
//  irq                 out  1        equals STATUS.done
// BEHAVIOUR
//  - Map: 0..N_SAMPLES-1 = sample window; N_SAMPLES+0 CTRL (W: b0 start, b1 clear
//    done/err); +1 STATUS (R: b0 busy, b1 done, b2 err); +2 COUNT (R: samples
//    loaded, saturates at N_SAMPLES). Other addresses: write ignored, read 0.
//  - Access accepted only when chipselect=1. write&read together: write wins,
//    read dropped (no readdatavalid).
//  - Sample write (state IDLE/LOAD/DONE): registered forward, 1-cycle latency:
//    sWriteEn=1, wAddress=addr[SAMP_AW-1:0], fft_init_data=writedata next cycle.
//    COUNT += 1 (saturating); IDLE/DONE -> LOAD. Write in BUSY: dropped, err=1.
//  - Sample-window read: rAddress driven combinationally from address; result
//    captured next cycle; readdata+readdatavalid on cycle 2. Register reads also
//    latency 2 (pipeline uniform). Back-to-back reads give one valid per read.
//  - FSM: IDLE -> LOAD (first sample write); LOAD/IDLE/DONE -> START (CTRL.b0);
//    START -> BUSY (fft_start=1 during START only, exactly 1 cycle); BUSY -> DONE
//    on fft_done; DONE -> IDLE on CTRL.b1. COUNT cleared on entering START.
//  - CTRL.b0 while START/BUSY: ignored, err=1. fft_done outside BUSY: ignored.
//    CTRL.b0 and b1 together: clear first, then start.
//  - Reset (any time, incl. mid-BUSY): state IDLE; all outputs 0 (slave_readdata,
//    slave_readdatavalid, sWriteEn, wAddress, fft_init_data, fft_start, rAddress
//    register, irq); COUNT=0, done=0, err=0; in-flight reads discarded.
// CONFIGURATION
//  AVS_AUTO_START_EN defined: the sample write that makes COUNT reach N_SAMPLES
//  also moves FSM to START in the following cycle (fft_start 2 cycles after the
//  write); CTRL.b0 still works. Undefined: start only via CTRL.b0; COUNT
//  saturates and no start occurs.
// TESTING
//  1 Reset then write 0xF0F0 to addr 0..N-1 -> sWriteEn 1 cycle after each write,
//    wAddress=addr, fft_init_data=0xF0F0; COUNT read = 512.
//  2 CTRL write 0x1 -> fft_start high exactly 1 cycle; STATUS=0x1; fft_done pulse
//    -> STATUS=0x2, irq=1; CTRL write 0x2 -> STATUS=0x0, irq=0.
//  3 Sample write and CTRL start during BUSY -> no sWriteEn, no fft_start,
//    STATUS=0x5.
//  4 Read addr 5 with fft_result_data=0x1234 at rAddress=5 -> readdatavalid
//    2 cycles later, readdata=0x1234; read addr 0x3FF -> 0x0000.
//  5 Assert n_rst mid-BUSY -> all outputs 0 asynchronously, STATUS=0, COUNT=0.
//  6 AVS_AUTO_START_EN: 512th sample write -> fft_start 2 cycles later; without
//    macro -> no fft_start.

Source files
------------

// File: rtl/avalon_fft_csr_slave.sv
// avalon_fft_csr_slave: Avalon-MM slave that loads FFT samples, sequences the core and returns results
// Ports:
//   clk, n_rst           clock and asynchronous active-low reset
//   slave_*              Avalon-MM slave; fixed read latency 2, write beats read
//   sWriteEn, wAddress,  registered forward of sample writes into the FFT input memory
//   fft_init_data
//   fft_start, fft_done  one-cycle start pulse to the core / completion pulse from it
//   rAddress,            result memory read port (data arrives one cycle after address)
//   fft_result_data
//   irq                  mirrors STATUS.done
// Build option: define AVS_AUTO_START_EN to start the core automatically once
// N_SAMPLES samples have been loaded.
module avalon_fft_csr_slave #(
   parameter int DATA_W    = 16,
   parameter int N_SAMPLES = 512,
   parameter int ADDR_W    = $clog2(N_SAMPLES) + 1
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              slave_chipselect,
   input  logic              slave_read,
   input  logic              slave_write,
   input  logic [ADDR_W-1:0] slave_address,
   input  logic [DATA_W-1:0] slave_writedata,
   output logic [DATA_W-1:0] slave_readdata,
   output logic              slave_readdatavalid,
   output logic              sWriteEn,
   output logic [ADDR_W-2:0] wAddress,
   output logic [DATA_W-1:0] fft_init_data,
   output logic              fft_start,
   input  logic              fft_done,
   output logic [ADDR_W-2:0] rAddress,
   input  logic [DATA_W-1:0] fft_result_data,
   output logic              irq
);
   localparam int SAMP_AW = ADDR_W - 1;
   localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, START = 3'd2, BUSY = 3'd3, DONE = 3'd4;
   logic [2:0] state;
   logic [ADDR_W-1:0] count;
   logic err, wr, rd, in_win, ctrl_hit, run, samp_ok, samp_bad, go, go_bad, clr, auto_go;
   logic rd_v1, win1;
   logic [DATA_W-1:0] reg_val, reg_val1;
   assign wr       = slave_chipselect & slave_write;
   assign rd       = slave_chipselect & slave_read & ~slave_write;
   assign in_win   = slave_address < ADDR_W'(N_SAMPLES);
   assign ctrl_hit = wr && slave_address == ADDR_W'(N_SAMPLES);
   // START and BUSY both count as "busy": samples and restarts are refused there
   assign run      = state == START || state == BUSY;
   assign samp_ok  = wr && in_win && !run;
   assign samp_bad = wr && in_win && run;
   assign go       = ctrl_hit && slave_writedata[0] && !run;
   assign go_bad   = ctrl_hit && slave_writedata[0] && run;
   assign clr      = ctrl_hit && slave_writedata[1];
   assign fft_start = state == START;
   assign irq       = state == DONE;
   assign rAddress  = (rd && in_win) ? slave_address[SAMP_AW-1:0] : '0;
   assign reg_val   = slave_address == ADDR_W'(N_SAMPLES + 1) ? DATA_W'({err, irq, run}) :
                      slave_address == ADDR_W'(N_SAMPLES + 2) ? DATA_W'(count) : '0;
`ifdef AVS_AUTO_START_EN
   // Remember that the last write filled the window; the FSM starts one cycle later
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) auto_go <= 1'b0;
      else auto_go <= samp_ok && count == ADDR_W'(N_SAMPLES - 1);
`else
   assign auto_go = 1'b0;
`endif
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= IDLE;
         count <= '0;
         err   <= 1'b0;
      end else begin
         // clear is applied before a start attempt that may set err again
         err <= (err & ~clr) | samp_bad | go_bad;
         if (go || (auto_go && state == LOAD)) begin
            state <= START;
            count <= '0;
         end else begin
            if (samp_ok && count != ADDR_W'(N_SAMPLES)) count <= count + ADDR_W'(1);
            if (clr && state == DONE) state <= IDLE;
            else if (samp_ok) state <= LOAD;
            else if (state == START) state <= BUSY;
            else if (state == BUSY && fft_done) state <= DONE;
         end
      end
   end
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sWriteEn      <= 1'b0;
         wAddress      <= '0;
         fft_init_data <= '0;
      end else begin
         sWriteEn <= samp_ok;
         if (samp_ok) begin
            wAddress      <= slave_address[SAMP_AW-1:0];
            fft_init_data <= slave_writedata;
         end
      end
   end
   // Two-stage read pipeline: stage 1 waits for the result memory, stage 2 drives the bus
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rd_v1               <= 1'b0;
         win1                <= 1'b0;
         reg_val1            <= '0;
         slave_readdatavalid <= 1'b0;
         slave_readdata      <= '0;
      end else begin
         rd_v1               <= rd;
         win1                <= in_win;
         reg_val1            <= reg_val;
         slave_readdatavalid <= rd_v1;
         slave_readdata      <= !rd_v1 ? '0 : win1 ? fft_result_data : reg_val1;
      end
   end
endmodule

// File: tb/tb_avalon_fft_csr_slave.sv
// tb_avalon_fft_csr_slave: directed self-checking bench for avalon_fft_csr_slave
module tb_avalon_fft_csr_slave;
   localparam int DW = 16, N = 512, AW = 10;
`ifdef AVS_AUTO_START_EN
   localparam logic AUTO = 1'b1;
`else
   localparam logic AUTO = 1'b0;
`endif
   logic clk = 1'b0, n_rst = 1'b0, cs = 1'b0, rd = 1'b0, wr = 1'b0, fft_done = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] wdata = '0, rdata, fft_init_data, fft_result_data = '0;
   logic rvalid, sWriteEn, fft_start, irq;
   logic [AW-2:0] wAddress, rAddress;
   int tests = 0, fails = 0;
   logic [DW-1:0] d;
   logic early, v;

   always #5 clk = ~clk;
   // Result memory model: word k holds 0x122F + k, one cycle after rAddress
   always @(posedge clk) fft_result_data <= 16'h122F + 16'(rAddress);

   avalon_fft_csr_slave #(.DATA_W(DW), .N_SAMPLES(N), .ADDR_W(AW)) dut (
      .clk(clk), .n_rst(n_rst), .slave_chipselect(cs), .slave_read(rd), .slave_write(wr),
      .slave_address(addr), .slave_writedata(wdata), .slave_readdata(rdata),
      .slave_readdatavalid(rvalid), .sWriteEn(sWriteEn), .wAddress(wAddress),
      .fft_init_data(fft_init_data), .fft_start(fft_start), .fft_done(fft_done),
      .rAddress(rAddress), .fft_result_data(fft_result_data), .irq(irq)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] x);
      cs = 1'b1; wr = 1'b1; addr = a; wdata = x;
      tick;
      cs = 1'b0; wr = 1'b0;
   endtask

   task automatic bus_read(input logic [AW-1:0] a, output logic [DW-1:0] x, output logic e, output logic ok);
      cs = 1'b1; rd = 1'b1; addr = a;
      tick;
      cs = 1'b0; rd = 1'b0;
      e = rvalid;
      tick;
      ok = rvalid;
      x = rdata;
   endtask

   task automatic pulse_done;
      fft_done = 1'b1;
      tick;
      fft_done = 1'b0;
   endtask

   task automatic test_reset;
      n_rst = 1'b0;
      tick; tick;
      tests++;
      if ({rdata, rvalid, sWriteEn, wAddress, fft_init_data, fft_start, rAddress, irq} !== 54'd0) begin
         fails++; $display("FAIL reset_outputs got %h want 0", {rdata, rvalid, sWriteEn, wAddress, fft_init_data, fft_start, rAddress, irq});
      end
      n_rst = 1'b1;
      tick;
      bus_read(AW'(N + 1), d, early, v);
      tests++;
      if ({early, v, d} !== {2'b01, 16'h0000}) begin fails++; $display("FAIL reset_status got %b%b %h want 01 0000", early, v, d); end
      bus_read(AW'(N + 2), d, early, v);
      tests++;
      if ({early, v, d} !== {2'b01, 16'h0000}) begin fails++; $display("FAIL reset_count got %b%b %h want 01 0000", early, v, d); end
   endtask

   task automatic test_load;
      for (int i = 0; i < N; i++) begin
         bus_write(AW'(i), 16'hF0F0);
         tests++;
         if ({sWriteEn, wAddress, fft_init_data} !== {1'b1, 9'(i), 16'hF0F0}) begin
            fails++; $display("FAIL load_fwd[%0d] got %b %h %h want 1 %h f0f0", i, sWriteEn, wAddress, fft_init_data, 9'(i));
         end
      end
      tests++;
      if (fft_start !== 1'b0) begin fails++; $display("FAIL auto_start_t1 got %b want 0", fft_start); end
      tick;
      tests++;
      if ({sWriteEn, fft_start} !== {1'b0, AUTO}) begin fails++; $display("FAIL auto_start_t2 got %b%b want 0%b", sWriteEn, fft_start, AUTO); end
      tick;
      tests++;
      if (fft_start !== 1'b0) begin fails++; $display("FAIL auto_start_t3 got %b want 0", fft_start); end
      bus_read(AW'(N + 2), d, early, v);
      tests++;
      if ({early, v, d} !== {2'b01, AUTO ? 16'd0 : 16'd512}) begin fails++; $display("FAIL load_count got %b%b %h want 01 %h", early, v, d, AUTO ? 16'd0 : 16'd512); end
`ifdef AVS_AUTO_START_EN
      pulse_done;
      bus_write(AW'(N), 16'h2);
`else
      bus_write(AW'(3), 16'h1111);
      bus_read(AW'(N + 2), d, early, v);
      tests++;
      if ({early, v, d} !== {2'b01, 16'd512}) begin fails++; $display("FAIL count_saturate got %b%b %h want 01 0200", early, v, d); end
`endif
   endtask

   task automatic test_run;
      bus_write(AW'(N), 16'h1);
      tests++;
      if (fft_start !== 1'b1) begin fails++; $display("FAIL start_pulse got %b want 1", fft_start); end
      tick;
      tests++;
      if (fft_start !== 1'b0) begin fails++; $display("FAIL start_width got %b want 0", fft_start); end
      bus_read(AW'(N + 1), d, early, v);
      tests++;
      if ({early, v, d} !== {2'b01, 16'h0001}) begin fails++; $display("FAIL status_busy got %b%b %h want 01 0001", early, v, d); end
      bus_read(AW'(N + 2), d, early, v);
      tests++;
      if ({early, v, d} !== {2'b01, 16'h0000}) begin fails++; $display("FAIL count_cleared got %b%b %h want 01 0000", early, v, d); end
      pulse_done;
      tests++;
      if (irq !== 1'b1) begin fails++; $display("FAIL irq_set got %b want 1", irq); end
      bus_read(AW'(N + 1), d, early, v);
      tests++;
      if ({early, v, d} !== {2'b01, 16'h0002}) begin fails++; $display("FAIL status_done got %b%b %h want 01 0002", early, v, d); end
      bus_write(AW'(N), 16'h2);
      tests++;
      if (irq !== 1'b0) begin fails++; $display("FAIL irq_clear got %b want 0", irq); end
      bus_read(AW'(N + 1), d, early, v);
      tests++;
      if ({early, v, d} !== {2'b01, 16'h0000}) begin fails++; $display("FAIL status_idle got %b%b %h want 01 0000", early, v, d); end
   endtask

   task automatic test_busy;
      bus_write(AW'(N), 16'h1);
      tick;
      bus_write(AW'(7), 16'hABCD);
      tests++;
      if (sWriteEn !== 1'b0) begin fails++; $display("FAIL busy_write_drop got %b want 0", sWriteEn); end
      bus_write(AW'(N), 16'h1);
      tests++;
      if (fft_start !== 1'b0) begin fails++; $display("FAIL busy_start_ignored got %b want 0", fft_start); end
      bus_read(AW'(N + 1), d, early, v);
      tests++;
      if ({early, v, d} !== {2'b01, 16'h0005}) begin fails++; $display("FAIL status_err got %b%b %h want 01 0005", early, v, d); end
      pulse_done;
      bus_read(AW'(N + 1), d, early, v);
      tests++;
      if ({early, v, d} !== {2'b01, 16'h0006}) begin fails++; $display("FAIL status_done_err got %b%b %h want 01 0006", early, v, d); end
      bus_write(AW'(N), 16'h3);
      tests++;
      if (fft_start !== 1'b1) begin fails++; $display("FAIL clear_then_start got %b want 1", fft_start); end
      tick;
      bus_read(AW'(N + 1), d, early, v);
      tests++;
      if ({early, v, d} !== {2'b01, 16'h0001}) begin fails++; $display("FAIL status_restart got %b%b %h want 01 0001", early, v, d); end
      pulse_done;
      bus_write(AW'(N), 16'h2);
      pulse_done;
      bus_read(AW'(N + 1), d, early, v);
      tests++;
      if ({early, v, d, irq} !== {2'b01, 16'h0000, 1'b0}) begin fails++; $display("FAIL done_outside_busy got %b%b %h irq %b want 01 0000 irq 0", early, v, d, irq); end
   endtask

   task automatic test_read;
      cs = 1'b1; rd = 1'b1; addr = AW'(5);
      #1;
      tests++;
      if (rAddress !== 9'd5) begin fails++; $display("FAIL raddress got %h want 005", rAddress); end
      tick;
      cs = 1'b0; rd = 1'b0;
      early = rvalid;
      tick;
      tests++;
      if ({early, rvalid, rdata} !== {2'b01, 16'h1234}) begin fails++; $display("FAIL sample_read got %b%b %h want 01 1234", early, rvalid, rdata); end
      tick;
      tests++;
      if (rvalid !== 1'b0) begin fails++; $display("FAIL valid_single got %b want 0", rvalid); end
      bus_read(AW'(10'h3FF), d, early, v);
      tests++;
      if ({early, v, d} !== {2'b01, 16'h0000}) begin fails++; $display("FAIL unmapped_read got %b%b %h want 01 0000", early, v, d); end
      cs = 1'b1; rd = 1'b1; addr = AW'(5);
      tick;
      addr = AW'(6);
      tick;
      cs = 1'b0; rd = 1'b0;
      tests++;
      if ({rvalid, rdata} !== {1'b1, 16'h1234}) begin fails++; $display("FAIL b2b_first got %b %h want 1 1234", rvalid, rdata); end
      tick;
      tests++;
      if ({rvalid, rdata} !== {1'b1, 16'h1235}) begin fails++; $display("FAIL b2b_second got %b %h want 1 1235", rvalid, rdata); end
      tick;
      tests++;
      if (rvalid !== 1'b0) begin fails++; $display("FAIL b2b_end got %b want 0", rvalid); end
      cs = 1'b1; wr = 1'b1; rd = 1'b1; addr = AW'(9); wdata = 16'h5A5A;
      tick;
      cs = 1'b0; wr = 1'b0; rd = 1'b0;
      early = rvalid;
      tests++;
      if ({sWriteEn, wAddress, fft_init_data} !== {1'b1, 9'd9, 16'h5A5A}) begin fails++; $display("FAIL write_wins got %b %h %h want 1 009 5a5a", sWriteEn, wAddress, fft_init_data); end
      tick;
      tests++;
      if ({early, rvalid} !== 2'b00) begin fails++; $display("FAIL read_dropped got %b%b want 00", early, rvalid); end
      wr = 1'b1; addr = AW'(10); wdata = 16'h7777;
      tick;
      wr = 1'b0;
      tests++;
      if (sWriteEn !== 1'b0) begin fails++; $display("FAIL no_chipselect got %b want 0", sWriteEn); end
   endtask

   task automatic test_async_reset;
      bus_write(AW'(3), 16'h3333);
      bus_write(AW'(4), 16'h4444);
      bus_read(AW'(N + 2), d, early, v);
      tests++;
      if ({early, v, d} !== {2'b01, 16'd3}) begin fails++; $display("FAIL count_before_reset got %b%b %h want 01 0003", early, v, d); end
      #2 n_rst = 1'b0;
      #2 n_rst = 1'b1;
      tick;
      bus_read(AW'(N + 2), d, early, v);
      tests++;
      if ({early, v, d} !== {2'b01, 16'd0}) begin fails++; $display("FAIL count_after_reset got %b%b %h want 01 0000", early, v, d); end
      bus_write(AW'(4), 16'h4444);
      bus_write(AW'(N), 16'h1);
      tick;
      bus_write(AW'(N), 16'h1);
      cs = 1'b1; rd = 1'b1; addr = AW'(5);
      tick;
      cs = 1'b0; rd = 1'b0;
      tick;
      tests++;
      if ({rvalid, rdata} !== {1'b1, 16'h1234}) begin fails++; $display("FAIL pre_reset_read got %b %h want 1 1234", rvalid, rdata); end
      #2 n_rst = 1'b0;
      #1;
      tests++;
      if ({rdata, rvalid, sWriteEn, wAddress, fft_init_data, fft_start, rAddress, irq} !== 54'd0) begin
         fails++; $display("FAIL async_reset_outputs got %h want 0", {rdata, rvalid, sWriteEn, wAddress, fft_init_data, fft_start, rAddress, irq});
      end
      #1 n_rst = 1'b1;
      tick;
      bus_read(AW'(N + 1), d, early, v);
      tests++;
      if ({early, v, d} !== {2'b01, 16'h0000}) begin fails++; $display("FAIL status_after_reset got %b%b %h want 01 0000", early, v, d); end
      bus_read(AW'(N + 2), d, early, v);
      tests++;
      if ({early, v, d} !== {2'b01, 16'h0000}) begin fails++; $display("FAIL count_after_busy_reset got %b%b %h want 01 0000", early, v, d); end
   endtask

   initial begin
      test_reset;
      test_load;
      test_run;
      test_busy;
      test_read;
      test_async_reset;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout got running want finished");
      $fatal(1, "timeout");
   end
endmodule
